latch_bank_arbiter: RTL



---
 rtl/latch_arb_pkg.sv | 18 +
 rtl/d_latch.sv | 15 +
 rtl/latch_word.sv | 22 ++
 rtl/latch_bank_arbiter.sv | 108 ++++++++++
 4 files changed

// File: rtl/latch_arb_pkg.sv
// Shared types and constants for the latch bank write arbiter.
// Latency: none (package only).
// Backpressure: none (package only).
package latch_arb_pkg;

  localparam int NUM_REQ   = 2;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  // Write sequencer states; every state except IDLE lasts one cycle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ENABLE = 2'd2,
    HOLD   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/d_latch.sv
// Single-bit level-sensitive storage cell: transparent while i_en is high.
// Latency: combinational while enabled, holds otherwise.
// Backpressure: none.
module d_latch (
  input  logic i_en,
  input  logic i_d,
  output logic o_q
);

  // Transparent on high enable, opaque (holding) on low enable.
  always_latch begin
    if (i_en) o_q <= i_d;
  end

endmodule

// File: rtl/latch_word.sv
// One storage entry: WIDTH latch cells sharing a single enable.
// Latency: combinational while enabled, holds otherwise.
// Backpressure: none.
module latch_word
  import latch_arb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    d_latch u_cell (
      .i_en (i_en),
      .i_d  (i_d[g]),
      .o_q  (o_q[g])
    );
  end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Two-requester write arbiter and setup/enable/hold sequencer for a latch bank.
// Latency: grant cycles 1-3 after request edge, latch enable cycle 2, ack cycle 3; read is combinational.
// Backpressure: requesters hold i_req until o_ack; one write per 4 cycles. LATCH_ARB_RR_EN selects round-robin.
module latch_bank_arbiter
  import latch_arb_pkg::*;
#(
  parameter int  WIDTH = DEF_WIDTH,
  parameter int  DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [AW-1:0]      i_addr0,
  input  logic [AW-1:0]      i_addr1,
  input  logic [WIDTH-1:0]   i_data0,
  input  logic [WIDTH-1:0]   i_data1,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [NUM_REQ-1:0] o_ack,
  output logic               o_busy,
  input  logic [AW-1:0]      i_raddr,
  output logic [WIDTH-1:0]   o_rdata
);

  localparam logic [DEPTH-1:0] ENTRY0 = {{(DEPTH-1){1'b0}}, 1'b1};

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  logic             r_win;
  logic [AW-1:0]    r_addr;
  logic [WIDTH-1:0] r_data;
  logic [DEPTH-1:0] r_en;
  logic             w_win;
  logic             w_capture;
  logic [WIDTH-1:0] w_q [DEPTH];

  assign w_capture = (r_state == IDLE) && (|i_req);

`ifdef LATCH_ARB_RR_EN
  // r_ptr remembers the last granted requester; a tie goes to the other one.
  logic r_ptr;

  assign w_win = (&i_req) ? ~r_ptr : i_req[1];

  // Round-robin pointer; reset to 1 so requester 0 wins the first tie.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       r_ptr <= 1'b1;
    else if (w_capture) r_ptr <= w_win;
  end
`else
  // Fixed priority: requester 0 wins whenever it is requesting.
  assign w_win = ~i_req[0];
`endif

  // Sequencer state register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and handshake outputs; grant/ack decode from registered state.
  always_comb begin
    w_state_nxt = r_state;
    o_gnt       = '0;
    o_ack       = '0;
    o_busy      = (r_state != IDLE);
    case (r_state)
      IDLE:    if (|i_req) w_state_nxt = SETUP;
      SETUP:   w_state_nxt = ENABLE;
      ENABLE:  w_state_nxt = HOLD;
      HOLD:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (r_state != IDLE) o_gnt[r_win] = 1'b1;
    if (r_state == HOLD) o_ack[r_win] = 1'b1;
  end

  // Capture winner, address and data; later input changes cannot disturb the write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_win  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_capture) begin
      r_win  <= w_win;
      r_addr <= w_win ? i_addr1 : i_addr0;
      r_data <= w_win ? i_data1 : i_data0;
    end
  end

  // Registered one-hot enable, high only during ENABLE so latch gates never glitch.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)              r_en <= '0;
    else if (r_state == SETUP) r_en <= ENTRY0 << r_addr;
    else                       r_en <= '0;
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_word
    latch_word #(.WIDTH(WIDTH)) u_word (
      .i_en (r_en[g]),
      .i_d  (r_data),
      .o_q  (w_q[g])
    );
  end

  assign o_rdata = w_q[i_raddr];

endmodule
